// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the shared iterative multiply/divide units.
// Issues start, waits for done or timeout, and commits results into HI/LO.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        op_done,
    output logic        div_zero_exc,
    output logic        timeout_err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        div_start,
    output logic        mult_start,
    output logic        unit_rst,
    input  logic        div_done,
    input  logic        div_by_zero,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT
    } state_t;

    localparam logic [6:0] LAST = 7'(TIMEOUT - 1);

    state_t      state, state_n;
    logic        is_div, is_div_n;
    logic [6:0]  cnt, cnt_n;
    logic [31:0] hi_n, lo_n, a_n, b_n;
    logic        busy_n, done_n, exc_n, to_n;
    logic        ds_n, ms_n;
    logic        abort_q, abort_n;

    always_comb begin
        state_n  = state;
        is_div_n = is_div;
        cnt_n    = cnt;
        hi_n     = hi;
        lo_n     = lo;
        a_n      = unit_a;
        b_n      = unit_b;
        done_n   = 1'b0;
        exc_n    = 1'b0;
        to_n     = 1'b0;
        ds_n     = 1'b0;
        ms_n     = 1'b0;
        abort_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (op_valid) begin
                    unique case (op_code)
                        2'b10: begin
                            hi_n   = rs_val;
                            done_n = 1'b1;
                        end
                        2'b11: begin
                            lo_n   = rs_val;
                            done_n = 1'b1;
                        end
                        default: begin
                            is_div_n = op_code[0];
                            a_n      = rs_val;
                            b_n      = rt_val;
                            ds_n     = op_code[0];
                            ms_n     = !op_code[0];
                            state_n  = S_ISSUE;
                        end
                    endcase
                end
            end
            S_ISSUE: state_n = S_SETTLE;
            S_SETTLE: begin
                // done may still be stale from the previous op here
                cnt_n   = 7'd0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (is_div && div_done) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                    if (div_by_zero) begin
                        exc_n = 1'b1;
                    end else begin
                        lo_n = div_q;
                        hi_n = div_r;
                    end
                end else if (!is_div && mult_done) begin
                    done_n  = 1'b1;
                    hi_n    = mult_hi;
                    lo_n    = mult_lo;
                    state_n = S_IDLE;
                end else if (cnt == LAST) begin
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                    abort_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 7'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            is_div       <= 1'b0;
            cnt          <= 7'd0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            unit_a       <= 32'd0;
            unit_b       <= 32'd0;
            busy         <= 1'b0;
            op_done      <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
            div_start    <= 1'b0;
            mult_start   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state        <= state_n;
            is_div       <= is_div_n;
            cnt          <= cnt_n;
            hi           <= hi_n;
            lo           <= lo_n;
            unit_a       <= a_n;
            unit_b       <= b_n;
            busy         <= busy_n;
            op_done      <= done_n;
            div_zero_exc <= exc_n;
            timeout_err  <= to_n;
            div_start    <= ds_n;
            mult_start   <= ms_n;
            abort_q      <= abort_n;
        end
    end

    assign unit_rst = !reset || abort_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a transaction-level timeline model.
// The bench also plays the divider and multiplier units.
module tb_muldiv_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] rs_val, rt_val;
    logic        busy, op_done, div_zero_exc, timeout_err;
    logic [31:0] hi, lo, unit_a, unit_b;
    logic        div_start, mult_start, unit_rst;
    logic        div_done, div_by_zero, mult_done;
    logic [31:0] div_q, div_r, mult_hi, mult_lo;

    always #5 clk = ~clk;

    muldiv_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .op_done(op_done),
        .div_zero_exc(div_zero_exc), .timeout_err(timeout_err),
        .hi(hi), .lo(lo), .unit_a(unit_a), .unit_b(unit_b),
        .div_start(div_start), .mult_start(mult_start),
        .unit_rst(unit_rst),
        .div_done(div_done), .div_by_zero(div_by_zero),
        .div_q(div_q), .div_r(div_r),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo)
    );

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic e_busy, e_done, e_exc, e_to, e_urst, e_ds, e_ms, e_ab;
    logic [31:0] e_hi, e_lo, e_a, e_b;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("op_done", 32'(op_done), 32'(e_done));
            check("div_zero_exc", 32'(div_zero_exc), 32'(e_exc));
            check("timeout_err", 32'(timeout_err), 32'(e_to));
            check("unit_rst", 32'(unit_rst), 32'(e_urst));
            check("div_start", 32'(div_start), 32'(e_ds));
            check("mult_start", 32'(mult_start), 32'(e_ms));
            check("hi", hi, e_hi);
            check("lo", lo, e_lo);
            if (e_ab) begin
                check("unit_a", unit_a, e_a);
                check("unit_b", unit_b, e_b);
            end
        end
    end

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // returns {remainder, quotient}, truncating signed division
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic quiet();
        e_busy = 1'b0; e_done = 1'b0; e_exc = 1'b0; e_to = 1'b0;
        e_urst = 1'b0; e_ds = 1'b0; e_ms = 1'b0; e_ab = 1'b0;
        e_hi = m_hi; e_lo = m_lo;
    endtask

    // k: WAIT cycle on which the unit raises done (0 or >TO: never in time)
    task automatic run_op(input logic [1:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int k,
                          input bit stale, input int rst_c);
        int len;
        bit to, exc, sel_div;
        logic [31:0] nh, nl;
        logic [63:0] r;
        op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
        nh = m_hi; nl = m_lo; to = 1'b0; exc = 1'b0;
        sel_div = (code == 2'b01);
        r = 64'd0;
        if (code == 2'b10) begin
            nh = a; len = 1;
        end else if (code == 2'b11) begin
            nl = a; len = 1;
        end else begin
            if (k >= 1 && k <= TO) len = k + 3;
            else begin len = TO + 3; to = 1'b1; end
            r = sel_div ? ((b == 0) ? 64'd0 : div_model(a, b)) : mul_model(a, b);
            if (!to) begin
                if (sel_div && b == 0) exc = 1'b1;
                else begin nh = r[63:32]; nl = r[31:0]; end
            end
        end
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            quiet();
            op_valid = (c < len) ? 1'($urandom) : 1'b0;
            op_code = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
            if (code[1] == 1'b0) begin
                logic sd;
                bit fresh;
                fresh = (c <= 2) ? 1'b0 : 1'b1;
                sd = (c <= 2) ? stale : (k >= 1 && (c - 2) >= k);
                if (sel_div) begin
                    div_done = sd;
                    div_by_zero = fresh ? (b == 0) : 1'($urandom);
                    div_q = fresh ? r[31:0] : $urandom;
                    div_r = fresh ? r[63:32] : $urandom;
                    mult_done = 1'($urandom);
                    mult_hi = $urandom; mult_lo = $urandom;
                end else begin
                    mult_done = sd;
                    mult_hi = fresh ? r[63:32] : $urandom;
                    mult_lo = fresh ? r[31:0] : $urandom;
                    div_done = 1'($urandom); div_by_zero = 1'($urandom);
                    div_q = $urandom; div_r = $urandom;
                end
            end
            e_busy = (c < len);
            e_ds = (c == 1) && (code == 2'b01);
            e_ms = (c == 1) && (code == 2'b00);
            e_done = (c == len);
            e_exc = (c == len) && exc;
            e_to = (c == len) && to;
            e_urst = e_to;
            e_ab = (c < len); e_a = a; e_b = b;
            if (c == len) begin m_hi = nh; m_lo = nl; end
            e_hi = m_hi; e_lo = m_lo;
            if (c == rst_c) begin
                reset = 1'b0;
                e_urst = 1'b1;
                @(posedge clk); #1;
                reset = 1'b1;
                op_valid = 1'b0;
                m_hi = 32'd0; m_lo = 32'd0;
                quiet();
                e_ab = 1'b1; e_a = 32'd0; e_b = 32'd0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            quiet();
        end
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_code = 2'b00;
        rs_val = 32'd0; rt_val = 32'd0;
        div_done = 1'b0; div_by_zero = 1'b0; div_q = 32'd0; div_r = 32'd0;
        mult_done = 1'b0; mult_hi = 32'd0; mult_lo = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        quiet(); e_urst = 1'b1; e_ab = 1'b1; e_a = 32'd0; e_b = 32'd0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        quiet();
        idle(2);

        // MTHI then MTLO issued on the op_done cycle
        run_op(2'b10, 32'hDEADBEEF, 32'd0, 0, 1'b0, 0);
        run_op(2'b11, 32'h00000001, 32'd0, 0, 1'b0, 0);
        idle(1);
        check("pin_mthi", hi, 32'hDEADBEEF);
        check("pin_mtlo", lo, 32'h00000001);

        run_op(2'b01, 32'hFFFFFFF9, 32'd2, 5, 1'b0, 0);
        idle(1);
        check("pin_div_lo", lo, 32'hFFFFFFFD);
        check("pin_div_hi", hi, 32'hFFFFFFFF);

        run_op(2'b00, 32'hFFFFFFFF, 32'd2, 3, 1'b0, 0);
        check("pin_mul_hi", m_hi, 32'hFFFFFFFF);
        check("pin_mul_lo", m_lo, 32'hFFFFFFFE);

        // stale divider done held through ISSUE/SETTLE
        run_op(2'b01, 32'd100, 32'd7, 4, 1'b1, 0);
        idle(1);
        check("pin_stale_lo", lo, 32'd14);
        check("pin_stale_hi", hi, 32'd2);

        run_op(2'b10, 32'h11, 32'd0, 0, 1'b0, 0);
        run_op(2'b11, 32'h22, 32'd0, 0, 1'b0, 0);
        run_op(2'b01, 32'd55, 32'd0, 2, 1'b0, 0);
        idle(1);
        check("pin_dz_hi", hi, 32'h11);
        check("pin_dz_lo", lo, 32'h22);

        run_op(2'b00, 32'd3, 32'd4, 0, 1'b0, 0);
        idle(1);
        check("pin_to_hi", hi, 32'h11);
        check("pin_to_lo", lo, 32'h22);

        // done on the very cycle the timeout would expire
        run_op(2'b01, 32'd9, 32'd4, TO, 1'b0, 0);
        idle(1);
        check("pin_edge_lo", lo, 32'd2);

        // reset during WAIT (counter 5)
        run_op(2'b01, 32'd81, 32'd9, 0, 1'b0, 8);
        idle(1);
        check("pin_rst_hi", hi, 32'd0);
        check("pin_rst_lo", lo, 32'd0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] code;
            logic [31:0] a, b;
            code = 2'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(code, a, b, int'($urandom_range(0, TO + 1)),
                   1'($urandom), 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
